score_controller: RTL and testbench

- Consumes the one-cycle short/long press pulses from the per-player press detectors and keeps the scoreboard state.
- Short press awards a point to that player. Long press undoes the most recent point.
- Detects game wins (WIN_POINTS, lead of 2), counts games won, holds the result for a display period, then starts a new game.
- Feeds the display/BCD stage downstream.

---
 rtl/score_controller.sv | 154 +++++++++++++++
 tb/tb_score_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/score_controller.sv
// Scoreboard controller: turns per-player short/long press pulses into scores,
// undo history, game wins, games-won counters and a timed game-over hold.
module score_controller #(
  parameter int unsigned WIN_POINTS  = 11,
  parameter int unsigned SCORE_W     = 5,
  parameter int unsigned GAMES_W     = 3,
  parameter int unsigned UNDO_DEPTH  = 8,
  parameter int unsigned HOLD_CYCLES = 200000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               a_short_i,
  input  logic               a_long_i,
  input  logic               b_short_i,
  input  logic               b_long_i,
  output logic [SCORE_W-1:0] score_a_o,
  output logic [SCORE_W-1:0] score_b_o,
  output logic [GAMES_W-1:0] games_a_o,
  output logic [GAMES_W-1:0] games_b_o,
  output logic               game_over_o,
  output logic               winner_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PTR_W  = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(UNDO_DEPTH + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [GAMES_W-1:0] GAMES_MAX = '1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HIST_FULL = CNT_W'(UNDO_DEPTH);

  typedef enum logic {PLAY, WON} state_e;

  state_e                  state_q;
  logic [SCORE_W-1:0]      score_a_q, score_b_q;
  logic [GAMES_W-1:0]      games_a_q, games_b_q;
  logic                    game_over_q, winner_q, games_incr_q;
  logic [HOLD_W-1:0]       hold_q;
  logic [UNDO_DEPTH-1:0]   hist_q;
  logic [PTR_W-1:0]        head_q;
  logic [CNT_W-1:0]        hist_cnt_q;

  logic               undo_c, hist_empty_c, pop_id_c, a_only_c, b_only_c;
  logic               a_wins_c, b_wins_c;
  logic [PTR_W-1:0]   pop_ptr_c;
  logic [SCORE_W-1:0] a_inc_c, b_inc_c;

  // Decode presses and evaluate the win condition on post-increment scores.
  always_comb begin
    undo_c       = a_long_i | b_long_i;
    hist_empty_c = (hist_cnt_q == '0);
    pop_ptr_c    = head_q - PTR_W'(1);
    pop_id_c     = hist_q[pop_ptr_c];
    a_only_c     = a_short_i & ~b_short_i;
    b_only_c     = b_short_i & ~a_short_i;
    a_inc_c      = score_a_q + SCORE_W'(1);
    b_inc_c      = score_b_q + SCORE_W'(1);
    // Widened operands keep "lead of 2" free of wrap-around.
    a_wins_c     = (32'(a_inc_c) >= WIN_POINTS) &&
                   ({1'b0, a_inc_c} >= ({1'b0, score_b_q} + (SCORE_W+1)'(2)));
    b_wins_c     = (32'(b_inc_c) >= WIN_POINTS) &&
                   ({1'b0, b_inc_c} >= ({1'b0, score_a_q} + (SCORE_W+1)'(2)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= PLAY;
      score_a_q    <= '0;
      score_b_q    <= '0;
      games_a_q    <= '0;
      games_b_q    <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      games_incr_q <= 1'b0;
      hold_q       <= '0;
      hist_q       <= '0;
      head_q       <= '0;
      hist_cnt_q   <= '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (undo_c) begin
            if (!hist_empty_c) begin
              head_q     <= pop_ptr_c;
              hist_cnt_q <= hist_cnt_q - CNT_W'(1);
              if (pop_id_c) score_b_q <= score_b_q - SCORE_W'(1);
              else          score_a_q <= score_a_q - SCORE_W'(1);
            end
          end else if ((a_only_c && score_a_q != SCORE_MAX) ||
                       (b_only_c && score_b_q != SCORE_MAX)) begin
            // Exactly one eligible point: push its player ID, oldest entry drops when full.
            hist_q[head_q] <= b_only_c;
            head_q         <= head_q + PTR_W'(1);
            if (hist_cnt_q != HIST_FULL) hist_cnt_q <= hist_cnt_q + CNT_W'(1);
            if (b_only_c) score_b_q <= b_inc_c;
            else          score_a_q <= a_inc_c;
            if ((a_only_c && a_wins_c) || (b_only_c && b_wins_c)) begin
              state_q     <= WON;
              game_over_q <= 1'b1;
              winner_q    <= b_only_c;
              hold_q      <= '0;
              if (b_only_c) begin
                games_incr_q <= (games_b_q != GAMES_MAX);
                if (games_b_q != GAMES_MAX) games_b_q <= games_b_q + GAMES_W'(1);
              end else begin
                games_incr_q <= (games_a_q != GAMES_MAX);
                if (games_a_q != GAMES_MAX) games_a_q <= games_a_q + GAMES_W'(1);
              end
            end
          end
        end
        WON: begin
          if (undo_c) begin
            // Undo of the winning point reopens the game and retracts the game credit.
            if (!hist_empty_c) begin
              head_q     <= pop_ptr_c;
              hist_cnt_q <= hist_cnt_q - CNT_W'(1);
              if (pop_id_c) score_b_q <= score_b_q - SCORE_W'(1);
              else          score_a_q <= score_a_q - SCORE_W'(1);
            end
            if (games_incr_q) begin
              if (winner_q) games_b_q <= games_b_q - GAMES_W'(1);
              else          games_a_q <= games_a_q - GAMES_W'(1);
            end
            games_incr_q <= 1'b0;
            game_over_q  <= 1'b0;
            hold_q       <= '0;
            state_q      <= PLAY;
          end else if (hold_q == HOLD_LAST) begin
            score_a_q   <= '0;
            score_b_q   <= '0;
            hist_cnt_q  <= '0;
            head_q      <= '0;
            game_over_q <= 1'b0;
            hold_q      <= '0;
            state_q     <= PLAY;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  assign score_a_o   = score_a_q;
  assign score_b_o   = score_b_q;
  assign games_a_o   = games_a_q;
  assign games_b_o   = games_b_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: points, undo, wins, deuce, hold timing and reset.
module tb_score_controller;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       a_short_i = 1'b0, a_long_i = 1'b0, b_short_i = 1'b0, b_long_i = 1'b0;
  logic [4:0] score_a_o, score_b_o;
  logic [2:0] games_a_o, games_b_o;
  logic       game_over_o, winner_o;

  int checks = 0;
  int failures = 0;

  score_controller #(
    .WIN_POINTS(11), .SCORE_W(5), .GAMES_W(3), .UNDO_DEPTH(4), .HOLD_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_short_i(a_short_i), .a_long_i(a_long_i),
    .b_short_i(b_short_i), .b_long_i(b_long_i),
    .score_a_o(score_a_o), .score_b_o(score_b_o),
    .games_a_o(games_a_o), .games_b_o(games_b_o),
    .game_over_o(game_over_o), .winner_o(winner_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the selected inputs; returns at the following falling edge.
  task automatic press(input logic as, input logic al, input logic bs, input logic bl);
    @(negedge clk_i);
    a_short_i = as; a_long_i = al; b_short_i = bs; b_long_i = bl;
    @(negedge clk_i);
    a_short_i = 1'b0; a_long_i = 1'b0; b_short_i = 1'b0; b_long_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic a_pts(input int n);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic b_pts(input int n);
    for (int i = 0; i < n; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Counts falling edges with game_over_o high, bounded.
  task automatic hold_len(output int n);
    n = 0;
    while (game_over_o && n < 64) begin
      n++;
      @(negedge clk_i);
    end
  endtask

  int n;

  initial begin
    #2;
    check("reset_score_a", score_a_o, 0);
    check("reset_score_b", score_b_o, 0);
    check("reset_games", {games_a_o, games_b_o}, 0);
    check("reset_over", game_over_o, 0);
    check("reset_winner", winner_o, 0);
    rst_i = 1'b0;

    // Basic scoring and undo of newest entries (A, then B)
    a_pts(2); b_pts(2); a_pts(1);
    check("basic_a", score_a_o, 3);
    check("basic_b", score_b_o, 2);
    check("basic_over", game_over_o, 0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("undo1_a", score_a_o, 2);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("undo2_b", score_b_o, 1);
    check("undo2_a", score_a_o, 2);

    // Straight win 11-0 and hold length
    do_reset();
    a_pts(10);
    check("pre_win_over", game_over_o, 0);
    a_pts(1);
    check("win_over", game_over_o, 1);
    check("win_winner", winner_o, 0);
    check("win_games_a", games_a_o, 1);
    check("win_score_a", score_a_o, 11);
    hold_len(n);
    check("hold_len", n, 16);
    check("post_hold_a", score_a_o, 0);
    check("post_hold_b", score_b_o, 0);
    check("post_hold_games_a", games_a_o, 1);

    // Deuce, A wins 12-10
    do_reset();
    for (int i = 0; i < 10; i++) begin a_pts(1); b_pts(1); end
    a_pts(1);
    check("deuce_11_10_over", game_over_o, 0);
    a_pts(1);
    check("deuce_12_10_over", game_over_o, 1);
    check("deuce_12_10_winner", winner_o, 0);

    // Deuce, B wins 13-11
    do_reset();
    for (int i = 0; i < 10; i++) begin a_pts(1); b_pts(1); end
    a_pts(1); b_pts(1); b_pts(1);
    check("deuce_11_12_over", game_over_o, 0);
    b_pts(1);
    check("deuce_b_over", game_over_o, 1);
    check("deuce_b_winner", winner_o, 1);
    check("deuce_b_games", games_b_o, 1);
    check("deuce_b_score", score_b_o, 13);

    // History depth 4: only four undos take effect
    do_reset();
    a_pts(6);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    check("depth_4_undos", score_a_o, 2);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("depth_5th_undo", score_a_o, 2);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    check("both_short_a", score_a_o, 2);
    check("both_short_b", score_b_o, 0);

    // Undo during WON
    do_reset();
    a_pts(11);
    check("won_undo_pre", game_over_o, 1);
    repeat (4) @(negedge clk_i);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("won_undo_over", game_over_o, 0);
    check("won_undo_a", score_a_o, 10);
    check("won_undo_games", games_a_o, 0);
    a_pts(1);
    check("rewin_a", score_a_o, 11);
    check("rewin_over", game_over_o, 1);
    check("rewin_games", games_a_o, 1);
    b_pts(1); a_pts(1);
    check("won_short_a", score_a_o, 11);
    check("won_short_b", score_b_o, 0);
    check("won_short_over", game_over_o, 1);

    // Async reset mid-hold
    do_reset();
    b_pts(11);
    hold_len(n);
    check("b_hold_len", n, 16);
    b_pts(11);
    check("b_two_games", games_b_o, 2);
    check("b_two_over", game_over_o, 1);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_games_b", games_b_o, 0);
    check("async_rst_score_b", score_b_o, 0);
    check("async_rst_over", game_over_o, 0);
    check("async_rst_winner", winner_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    b_pts(1);
    check("after_rst_b", score_b_o, 1);
    check("after_rst_a", score_a_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
